// File: rtl/pack_i64_stream.sv
// LEB128 stream encoder. It accepts one 64-bit value per handshake and emits
// the encoding one byte per cycle, low group first. Bit 7 of each byte is the
// continuation flag. SIGNED selects sLEB128 (1) or unsigned LEB128 (0).
module pack_i64_stream #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [63:0] i_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic [3:0]  o_idx,
  output logic [3:0]  o_len
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_nxt;
  logic [63:0] sr;
  logic [63:0] rem;
  logic [6:0]  grp;
  logic [3:0]  idx, len, len_calc;
  logic        last, emit, done, accept;

  // Byte count is the smallest k for which the value fits in 7*k bits.
  // Signed: every bit from 7k-1 upward must copy the sign bit.
  // Unsigned: every bit from 7k upward must be zero.
  function automatic logic [3:0] calc_len(input logic [63:0] v);
    logic [3:0]  n;
    logic [63:0] hi;
    n = 4'd10;
    for (int k = 9; k >= 1; k--) begin
      if (SIGNED) begin
        hi = $signed(v) >>> (7 * k - 1);
        if (hi == '0 || hi == '1) n = 4'(k);
      end else begin
        hi = v >> (7 * k);
        if (hi == '0) n = 4'(k);
      end
    end
    return n;
  endfunction

  assign grp      = sr[6:0];
  assign len_calc = calc_len(i_data);
  assign emit     = (state == EMIT);
  assign done     = emit & o_ready & last;
  // A value can be taken in the cycle that the previous value's last byte
  // leaves, so consecutive values stream with no gap.
  assign i_ready  = ~emit | done;
  assign accept   = i_valid & i_ready;

  // Form the current group and decide whether it terminates the value.
  always_comb begin
    rem  = '0;
    last = 1'b0;
    if (SIGNED) begin
      rem  = $signed(sr) >>> 7;
      last = (rem == '0 && !grp[6]) || (rem == '1 && grp[6]);
    end else begin
      rem  = sr >> 7;
      last = (rem == '0);
    end
    // Ten groups cover 70 bits. Index 9 must therefore close the value.
    if (idx == 4'd9) last = 1'b1;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EMIT;
      EMIT:    if (done)   state_nxt = accept ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath. Load the value on accept and shift one group per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      idx <= '0;
      len <= '0;
    end else if (accept) begin
      sr  <= i_data;
      idx <= '0;
      len <= len_calc;
    end else if (emit && o_ready && !last) begin
      sr  <= rem;
      idx <= idx + 4'd1;
    end
  end

  assign o_valid = emit;
  assign o_data  = emit ? {~last, grp} : 8'h00;
  assign o_last  = emit & last;
  assign o_idx   = emit ? idx : 4'd0;
  assign o_len   = emit ? len : 4'd0;

endmodule
